// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin codes
// and coin values in 5-cent units.
package change_pkg;

  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_t;

  typedef enum logic [1:0] {
    COIN_Q = 2'b00,
    COIN_D = 2'b01,
    COIN_N = 2'b10
  } coin_t;

  localparam int VAL_Q       = 5;
  localparam int VAL_D       = 2;
  localparam int VAL_N       = 1;
  localparam int TIMEOUT_DEF = 255;

  function automatic int coin_val(input logic [1:0] code);
    case (code)
      COIN_Q:  return VAL_Q;
      COIN_D:  return VAL_D;
      COIN_N:  return VAL_N;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin choice: largest coin that fits in rem and whose hopper is not empty.
module change_coin_select
  import change_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] rem,
  input  logic [2:0]       hopper_empty,
  input  logic             fault,
  output logic             coin_found,
  output logic [1:0]       coin_type,
  output logic [AMT_W-1:0] coin_value
);

  always_comb begin
    coin_found = 1'b0;
    coin_type  = COIN_Q;
    coin_value = '0;
    // Once faulted the hopper is untrusted, so nothing more is paid out.
    if (!fault) begin
      if (rem >= AMT_W'(VAL_Q) && !hopper_empty[0]) begin
        coin_found = 1'b1;
        coin_type  = COIN_Q;
        coin_value = AMT_W'(VAL_Q);
      end else if (rem >= AMT_W'(VAL_D) && !hopper_empty[1]) begin
        coin_found = 1'b1;
        coin_type  = COIN_D;
        coin_value = AMT_W'(VAL_D);
      end else if (rem >= AMT_W'(VAL_N) && !hopper_empty[2]) begin
        coin_found = 1'b1;
        coin_type  = COIN_N;
        coin_value = AMT_W'(VAL_N);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts an amount, ejects coins one at a time through a
// valid/ack hopper handshake, reports shortfall and raises a sticky fault on timeout.
module change_dispenser
  import change_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AMT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic [2:0]       hopper_empty,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [3:0]       coin_count,
  output logic             fault
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] sel_value;
  logic [AMT_W-1:0] ack_value;
  logic [1:0]       sel_type;
  logic             sel_found;
  logic [WD_W-1:0]  wd;
  logic             timeout;

  change_coin_select #(.AMT_W(AMT_W)) u_sel (
    .rem          (rem),
    .hopper_empty (hopper_empty),
    .fault        (fault),
    .coin_found   (sel_found),
    .coin_type    (sel_type),
    .coin_value   (sel_value)
  );

  // The registered coin_type carries the value of the coin being ejected;
  // the selector never picks a coin larger than rem, so rem cannot underflow.
  assign ack_value = AMT_W'(coin_val(coin_type));
  // An ack in the timeout cycle takes priority over the fault.
  assign timeout   = !coin_ack && (wd == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    coin_valid = 1'b0;
    done       = 1'b0;
    shortfall  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SELECT;
      end
      SELECT:   state_nxt = sel_found ? DISPENSE : DONE;
      DISPENSE: begin
        coin_valid = 1'b1;
        if (coin_ack)     state_nxt = SELECT;
        else if (timeout) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        shortfall = rem;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      coin_count <= '0;
      coin_type  <= COIN_Q;
      wd         <= '0;
      fault      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          rem        <= req_amount;
          coin_count <= '0;
        end
        SELECT: if (sel_found) begin
          coin_type <= sel_type;
          wd        <= '0;
        end
        DISPENSE: begin
          if (coin_ack) begin
            rem <= rem - ack_value;
            if (coin_count != 4'hF) coin_count <= coin_count + 4'd1;
          end else if (timeout) begin
            fault <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles coin_valid may wait for coin_ack before a fault.
REQ-002 Parameter AMT_W, default 8, is the width of every amount, in 5-cent units.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port list, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  change request present
- req_amount  in  AMT_W  change owed, 5-cent units
- req_ready  out  1  block idle, able to accept a request
- hopper_empty  in  3  per-type empty flags: [0] quarter, [1] dime, [2] nickel
- coin_valid  out  1  eject one coin of type coin_type
- coin_type  out  2  coin code: 00 quarter, 01 dime, 10 nickel
- coin_ack  in  1  hopper confirms the coin was ejected
- done  out  1  one-cycle pulse, request complete
- shortfall  out  AMT_W  amount not paid out, valid while done is high
- coin_count  out  4  coins ejected for the current or last request, saturating at 15
- fault  out  1  sticky hopper-timeout flag

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, SELECT, DISPENSE, DONE.
REQ-006 In IDLE:
- req_ready = 1.
- On req_valid && req_ready: latch req_amount into rem, clear coin_count, go to SELECT.
REQ-007 req_ready SHALL be 0 in every state other than IDLE; requests presented then are ignored, not queued.
REQ-008 SELECT SHALL take one cycle and choose a coin greedily from rem and hopper_empty, sampled in that cycle:
- quarter (5 units) if rem >= 5 and hopper_empty[0] = 0;
- else dime (2 units) if rem >= 2 and hopper_empty[1] = 0;
- else nickel (1 unit) if rem >= 1 and hopper_empty[2] = 0;
- else go to DONE.
REQ-009 When a coin is chosen, the next state SHALL be DISPENSE, with coin_type registered.
REQ-010 In DISPENSE:
- coin_valid = 1.
- coin_type SHALL be held stable until coin_ack.
REQ-011 On coin_ack in DISPENSE:
- rem SHALL decrease by the coin value.
- coin_count SHALL increment, saturating at 15.
- Next state SHALL be SELECT; coin_valid drops in that cycle.
REQ-012 coin_ack outside DISPENSE SHALL be ignored.
REQ-013 Watchdog in DISPENSE:
- A watchdog counter SHALL count cycles spent in DISPENSE and clear on entry to DISPENSE.
- If it reaches TIMEOUT with no coin_ack: set fault, go to DONE, leave rem unchanged.
- coin_ack arriving in the same cycle as the timeout SHALL win: the coin is counted and no fault is raised.
REQ-014 In DONE:
- done = 1 and shortfall = rem, for one cycle.
- Next state SHALL be IDLE.
- Minimum latency for req_amount = 0 is accept, SELECT, DONE: done high 2 cycles after acceptance.
REQ-015 fault SHALL stay set until reset.
REQ-016 While fault = 1, SELECT SHALL go directly to DONE; no further coins are ejected.
REQ-017 rem SHALL never underflow; the coin value subtracted is never greater than rem.

Reset
REQ-018 rst_n low SHALL asynchronously force all of the following, regardless of state, including mid-dispense:
- state = IDLE
- coin_valid, done, fault = 0
- shortfall, coin_count, rem, watchdog = 0
- coin_type = 00
REQ-019 After reset release, req_ready SHALL be 1 on the first clock edge.

Structure
REQ-020 Shared package change_pkg SHALL hold:
- the state enumeration;
- coin_type codes;
- coin values (5, 2, 1);
- the default TIMEOUT.
REQ-021 The greedy choice SHALL be placed in one combinational sub-module, change_coin_select:
- inputs: rem, hopper_empty, fault;
- outputs: coin_found, coin_type, coin_value.
REQ-022 The FSM, rem, coin_count and watchdog SHALL reside in change_dispenser.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Amount 13, all hoppers full, ack 1 cycle after each coin_valid -> coins Q,Q,D,N; coin_count 4; shortfall 0; fault 0.
- Amount 7, hopper_empty = 001 -> coins D,D,D,N; coin_count 4; shortfall 0.
- Amount 3, hopper_empty = 111 -> no coin_valid; done 2 cycles after acceptance; shortfall 3; coin_count 0.
- Amount 0 -> done 2 cycles after acceptance; shortfall 0; no coin_valid.
- Amount 5, coin_ack never asserted -> fault set after 255 DISPENSE cycles; done with shortfall 5. A following request for amount 2 -> no coins; shortfall 2.
- Amount 10, rst_n pulsed low during the second DISPENSE -> coin_valid drops immediately; all outputs 0; req_ready 1 after release.
